// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port RAM between two requesters: A (UART side) and B (sign side).
// Ownership goes round-robin on contention, and every hand-over passes through an
// idle bubble. A contended grant is pre-empted after MAX_BURST accesses unless the
// holder asserts its lock. Reads are tagged with the issuer. Exactly one cycle later
// that issuer sees rvalid.
//
// Ports
//   sys_clk, sys_rst_n          : clock, async active-low reset
//   a_req/a_lock/a_we/a_addr/a_wdata : requester A access request
//   a_gnt/a_rvalid/a_rdata      : requester A grant and read return
//   b_*                         : same set for requester B
//   ram_en/ram_we/ram_addr/ram_din : RAM drive
//   ram_dout                    : RAM read data (1-cycle latency)
//   busy                        : any grant held
//   owner                       : last/current owner (0=A, 1=B)
module ram_port_arbiter #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              a_req,
    input  logic              a_lock,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_lock,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;

    localparam logic [7:0] MaxCnt = 8'(MAX_BURST);

    state_e      r_state, w_state_nxt;
    logic        r_owner, w_owner_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic        r_rd_pend, r_rd_tag;

    logic              w_sel_b, w_granted, w_access, w_limit;
    logic              w_req, w_lock, w_we, w_other_req;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Mux the current holder's request onto a common set of signals.
    assign w_sel_b     = (r_state == StGntB);
    assign w_granted   = (r_state != StIdle);
    assign w_req       = w_sel_b ? b_req   : a_req;
    assign w_lock      = w_sel_b ? b_lock  : a_lock;
    assign w_we        = w_sel_b ? b_we    : a_we;
    assign w_addr      = w_sel_b ? b_addr  : a_addr;
    assign w_wdata     = w_sel_b ? b_wdata : a_wdata;
    assign w_other_req = w_sel_b ? a_req   : b_req;
    assign w_access    = w_granted & w_req;

    // The limit counts the access issued this cycle. A pre-empted holder therefore
    // gets exactly MAX_BURST accesses before the bubble.
    assign w_cnt_inc = (w_access && (r_cnt != MaxCnt)) ? r_cnt + 8'd1 : r_cnt;
    assign w_limit   = (w_cnt_inc == MaxCnt);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = w_cnt_inc;
        unique case (r_state)
            StIdle: begin
                if (a_req && b_req) begin
                    w_state_nxt = r_owner ? StGntA : StGntB;
                end else if (a_req) begin
                    w_state_nxt = StGntA;
                end else if (b_req) begin
                    w_state_nxt = StGntB;
                end
                if (a_req || b_req) begin
                    w_owner_nxt = (w_state_nxt == StGntB);
                    w_cnt_nxt   = 8'd0;
                end
            end
            StGntA, StGntB: begin
                if (!w_lock && (!w_req || (w_limit && w_other_req))) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= StIdle;
            r_owner   <= 1'b1;
            r_cnt     <= 8'd0;
            r_rd_pend <= 1'b0;
            r_rd_tag  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_pend <= w_access & ~w_we;
            r_rd_tag  <= w_sel_b;
        end
    end

    assign a_gnt    = (r_state == StGntA);
    assign b_gnt    = w_sel_b;
    assign busy     = w_granted;
    assign owner    = r_owner;

    assign ram_en   = w_access;
    assign ram_we   = w_access & w_we;
    assign ram_addr = w_granted ? w_addr  : '0;
    assign ram_din  = w_granted ? w_wdata : '0;

    assign a_rvalid = r_rd_pend & ~r_rd_tag;
    assign b_rvalid = r_rd_pend &  r_rd_tag;
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter. It combines directed scenarios with a
// randomized phase. A behavioural model predicts grants and RAM drive every cycle.
// When a read is issued, the model queues the expected read return. A monitor checks
// each rvalid against that queue.
module tb_ram_port_arbiter;

    localparam int AW  = 15;
    localparam int DW  = 8;
    localparam int MAX = 64;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          a_req = 0, a_lock = 0, a_we = 0, b_req = 0, b_lock = 0, b_we = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_en, ram_we, busy, owner;
    logic [DW-1:0] a_rdata, b_rdata, ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic [AW-1:0] ram_addr;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAX)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy), .owner(owner)
    );

    always #5 sys_clk = ~sys_clk;

    // RAM attached to the DUT
    bit [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge sys_clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state
    typedef struct {int who; int due; logic [DW-1:0] data;} exp_t;
    exp_t        q[$];
    bit [DW-1:0] ref_mem [0:(1<<AW)-1];
    int          m_holder = -1;   // -1 none, 0 A, 1 B
    int          m_owner  = 1;
    int          m_cnt    = 0;
    int          cyc      = 0;
    int          a_rv_cnt = 0;
    int          a_acc_cnt = 0;

    task automatic model_reset();
        m_holder = -1;
        m_owner  = 1;
        m_cnt    = 0;
        q.delete();
    endtask

    // Called at a negedge with inputs already driven; checks this cycle, advances model.
    task automatic step();
        bit            req_h, lock_h, we_h, other, access;
        logic [AW-1:0] addr_h;
        logic [DW-1:0] wd_h;
        int            served;
        #1;
        req_h  = (m_holder == 0) ? a_req  : (m_holder == 1) ? b_req  : 1'b0;
        lock_h = (m_holder == 0) ? a_lock : (m_holder == 1) ? b_lock : 1'b0;
        we_h   = (m_holder == 0) ? a_we   : (m_holder == 1) ? b_we   : 1'b0;
        addr_h = (m_holder == 0) ? a_addr : (m_holder == 1) ? b_addr : '0;
        wd_h   = (m_holder == 0) ? a_wdata : (m_holder == 1) ? b_wdata : '0;
        other  = (m_holder == 0) ? b_req  : a_req;
        access = (m_holder >= 0) && req_h;

        check("ctrl{agnt,bgnt,busy,owner,en,we}",
              32'({a_gnt, b_gnt, busy, owner, ram_en, ram_we}),
              32'({m_holder == 0, m_holder == 1, m_holder >= 0, m_owner == 1,
                   access, access && we_h}));
        check("ram_addr", 32'(ram_addr), 32'(addr_h));
        check("ram_din", 32'(ram_din), 32'(wd_h));
        if (a_gnt && ram_en) a_acc_cnt++;

        if (access) begin
            if (we_h) ref_mem[addr_h] = wd_h;
            else      q.push_back('{who: m_holder, due: cyc + 1, data: ref_mem[addr_h]});
        end

        if (m_holder < 0) begin
            if (a_req && b_req) m_holder = (m_owner == 1) ? 0 : 1;
            else if (a_req)     m_holder = 0;
            else if (b_req)     m_holder = 1;
            if (m_holder >= 0) begin
                m_owner = m_holder;
                m_cnt   = 0;
            end
        end else begin
            served = (m_cnt + (access ? 1 : 0) > MAX) ? MAX : m_cnt + (access ? 1 : 0);
            m_cnt  = served;
            if (!lock_h && (!req_h || (served == MAX && other))) m_holder = -1;
        end
        @(negedge sys_clk);
    endtask

    task automatic idle_inputs();
        a_req = 0; a_lock = 0; a_we = 0; b_req = 0; b_lock = 0; b_we = 0;
    endtask

    // Monitor: pops the scoreboard whenever a read return is presented.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            cyc++;
            #2;
            if (a_rvalid && b_rvalid) check("both_rvalid", 32'(1), 32'(0));
            if (a_rvalid) a_rv_cnt++;
            if (a_rvalid || b_rvalid) begin
                if (q.size() == 0) begin
                    check("unexpected_rvalid", 32'({b_rvalid, a_rvalid}), 32'(0));
                end else begin
                    e = q.pop_front();
                    check("rvalid_who", 32'({b_rvalid, a_rvalid}), 32'(e.who == 1 ? 2 : 1));
                    check("rvalid_cycle", 32'(cyc), 32'(e.due));
                    check("rdata", 32'(e.who == 1 ? b_rdata : a_rdata), 32'(e.data));
                    check("rdata_shared", 32'(a_rdata), 32'(b_rdata));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                check("missing_rvalid", 32'(0), 32'(e.who == 1 ? 2 : 1));
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge sys_clk);
        check("reset_outs{agnt,bgnt,arv,brv,en,we,busy}",
              32'({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_en, ram_we, busy}), 32'(0));
        check("reset_owner", 32'(owner), 32'(1));
        check("reset_addr_din", 32'({ram_addr, ram_din}), 32'(0));

        // Both request at release: A wins first contention, then holds 64 reads,
        // is pre-empted, and B takes over after one bubble.
        model_reset();
        sys_rst_n = 1'b1;
        a_req = 1; b_req = 1; a_we = 0; b_we = 0;
        a_rv_cnt = 0; a_acc_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            a_addr = AW'(i);
            step();
        end
        idle_inputs();
        repeat (3) step();
        check("burst_a_accesses", 32'(a_acc_cnt), 32'(MAX));
        check("burst_a_rvalids", 32'(a_rv_cnt), 32'(MAX));

        // A writes 0x5A at 0x1234, then B reads it back
        a_req = 1; a_we = 1; a_addr = 15'h1234; a_wdata = 8'h5A;
        repeat (2) step();
        a_req = 0; a_we = 0;
        b_req = 1; b_we = 0; b_addr = 15'h1234;
        repeat (4) step();
        idle_inputs();
        repeat (3) step();

        // B locked past saturation with A waiting: no pre-emption, access only on b_req
        b_req = 1; b_lock = 1; b_addr = 15'h0010;
        repeat (2) step();
        a_req = 1;
        repeat (MAX + 6) step();
        foreach (a_addr[i]) ; // keep addr stable
        b_req = 1; step();
        b_req = 0; step();
        b_req = 0; step();
        b_req = 1; step();
        b_lock = 0;
        repeat (4) step();
        idle_inputs();
        repeat (3) step();

        // Reset pulse during a B read burst drops the in-flight return
        b_req = 1; b_we = 0; b_addr = 15'h1234;
        repeat (3) step();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        model_reset();
        idle_inputs();
        #2;
        check("async_rst_outs{agnt,bgnt,arv,brv,en,we,busy}",
              32'({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_en, ram_we, busy}), 32'(0));
        check("async_rst_owner", 32'(owner), 32'(1));
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) step();
        a_req = 1; a_addr = 15'h1234;
        repeat (3) step();
        idle_inputs();
        repeat (2) step();

        // Randomized traffic over a small address window so reads hit written data
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) < 3) a_req = 1'($urandom_range(1));
            if ($urandom_range(9) < 3) b_req = 1'($urandom_range(1));
            a_lock  = ($urandom_range(19) == 0);
            b_lock  = ($urandom_range(19) == 0);
            a_we    = 1'($urandom_range(1));
            b_we    = 1'($urandom_range(1));
            a_addr  = AW'($urandom_range(15));
            b_addr  = AW'($urandom_range(15));
            a_wdata = DW'($urandom);
            b_wdata = DW'($urandom);
            step();
        end
        idle_inputs();
        repeat (4) step();
        check("scoreboard_drained", 32'(q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
